// File: rtl/uart_word_interface_pkg.sv
// Shared constants for the UART word interface: default byte width,
// TX serializer state encoding and a ceil-log2 helper for sizing counters.
package uart_word_interface_pkg;

   localparam int NB_BYTE = 8;

   localparam logic [1:0] ST_IDLE   = 2'b00;
   localparam logic [1:0] ST_SEND   = 2'b01;
   localparam logic [1:0] ST_WAIT   = 2'b10;
   localparam logic [1:0] ST_FINISH = 2'b11;

   function automatic int clog2(input int value);
      int res;
      int v;
      res = 0;
      v   = value - 1;
      while (v > 0) begin
         res = res + 1;
         v   = v >> 1;
      end
      return res;
   endfunction

   function automatic int clog2_min1(input int value);
      int res;
      res = clog2(value);
      return (res < 1) ? 1 : res;
   endfunction

endpackage

// File: rtl/uart_word_serializer.sv
// TX path: latches one word and hands it to the UART transmitter byte by
// byte, LSB first, advancing on each transmitter done pulse.
module uart_word_serializer
   import uart_word_interface_pkg::*;
#(
   parameter int NB_WORD = 32,
   parameter int NB_BYTE = uart_word_interface_pkg::NB_BYTE
) (
   input  logic               clk,
   input  logic               i_reset,
   input  logic [NB_WORD-1:0] i_tx_word,
   input  logic               i_tx_word_valid,
   output logic               o_tx_word_ready,
   output logic               o_tx_start,
   output logic [NB_BYTE-1:0] o_tx_data,
   input  logic               i_tx_done,
   output logic               o_tx_word_done
);

   localparam int NB_BYTES = NB_WORD / NB_BYTE;
   localparam int IDX_W    = clog2_min1(NB_BYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_BYTES - 1);

   logic [1:0]         state_q, state_d;
   logic [NB_WORD-1:0] word_q, word_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [NB_BYTE-1:0] byte_s;

   // Next-state logic for the serializer FSM.
   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      idx_d   = idx_q;
      case (state_q)
         ST_IDLE: begin
            if (i_tx_word_valid) begin
               word_d  = i_tx_word;
               idx_d   = '0;
               state_d = ST_SEND;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SEND: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (i_tx_done) begin
               if (idx_q == LAST_IDX) begin
                  state_d = ST_FINISH;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = ST_SEND;
               end
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Byte selector; held stable while waiting on the transmitter.
   always_comb begin
      byte_s = '0;
      for (int b = 0; b < NB_BYTES; b++) begin
         if (idx_q == IDX_W'(b)) begin
            byte_s = word_q[b*NB_BYTE +: NB_BYTE];
         end else begin
            byte_s = byte_s;
         end
      end
   end

   // State, latched word and byte index registers.
   always_ff @(posedge clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= ST_IDLE;
         word_q  <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         idx_q   <= idx_d;
      end
   end

   assign o_tx_word_ready = (state_q == ST_IDLE);
   assign o_tx_start      = (state_q == ST_SEND);
   assign o_tx_word_done  = (state_q == ST_FINISH);
   assign o_tx_data       = byte_s;

endmodule

// File: rtl/uart_word_interface.sv
// Word-level front end for a byte UART: RX byte assembly with an inter-byte
// timeout, and a TX serializer sub-module.
module uart_word_interface
   import uart_word_interface_pkg::*;
#(
   parameter int NB_WORD        = 32,
   parameter int NB_BYTE        = uart_word_interface_pkg::NB_BYTE,
   parameter int TIMEOUT_CYCLES = 4_500_000
) (
   input  logic               clk,
   input  logic               i_reset,
   input  logic               i_rx_done,
   input  logic [NB_BYTE-1:0] i_rx_data,
   output logic [NB_WORD-1:0] o_rx_word,
   output logic               o_rx_word_valid,
   output logic               o_rx_error,
   input  logic [NB_WORD-1:0] i_tx_word,
   input  logic               i_tx_word_valid,
   output logic               o_tx_word_ready,
   output logic               o_tx_start,
   output logic [NB_BYTE-1:0] o_tx_data,
   input  logic               i_tx_done,
   output logic               o_tx_word_done
);

   localparam int NB_BYTES = NB_WORD / NB_BYTE;
   localparam int IDX_W    = clog2_min1(NB_BYTES);
   localparam int TO_W     = (TIMEOUT_CYCLES > 1) ? clog2_min1(TIMEOUT_CYCLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_BYTES - 1);
   // The expiring cycle is the one whose edge would take the counter to TIMEOUT_CYCLES-1.
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES - 2 : 0);
   localparam bit               TO_EN    = (TIMEOUT_CYCLES != 0);

   logic [IDX_W-1:0]   rx_cnt_q, rx_cnt_d;
   logic [NB_WORD-1:0] rx_buf_q, rx_buf_d;
   logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
   logic [NB_WORD-1:0] rx_word_q, rx_word_d;
   logic               rx_valid_q, rx_valid_d;
   logic               rx_err_q, rx_err_d;
   logic               expire_s;

   assign expire_s = TO_EN && (rx_cnt_q != '0) && (to_cnt_q == TO_LAST);

   // RX assembly and timeout; an arriving byte takes priority over expiry.
   always_comb begin
      rx_cnt_d   = rx_cnt_q;
      rx_buf_d   = rx_buf_q;
      to_cnt_d   = to_cnt_q;
      rx_word_d  = rx_word_q;
      rx_valid_d = 1'b0;
      rx_err_d   = 1'b0;
      if (i_rx_done) begin
         for (int b = 0; b < NB_BYTES; b++) begin
            if (rx_cnt_q == IDX_W'(b)) begin
               rx_buf_d[b*NB_BYTE +: NB_BYTE] = i_rx_data;
            end else begin
               rx_buf_d[b*NB_BYTE +: NB_BYTE] = rx_buf_q[b*NB_BYTE +: NB_BYTE];
            end
         end
         to_cnt_d = '0;
         if (rx_cnt_q == LAST_IDX) begin
            rx_word_d  = rx_buf_d;
            rx_valid_d = 1'b1;
            rx_cnt_d   = '0;
         end else begin
            rx_cnt_d = rx_cnt_q + IDX_W'(1);
         end
      end else if (expire_s) begin
         rx_cnt_d = '0;
         to_cnt_d = '0;
         rx_err_d = 1'b1;
      end else if (TO_EN && (rx_cnt_q != '0)) begin
         to_cnt_d = to_cnt_q + TO_W'(1);
      end else begin
         to_cnt_d = '0;
      end
   end

   // RX state and output registers.
   always_ff @(posedge clk or negedge i_reset) begin
      if (!i_reset) begin
         rx_cnt_q   <= '0;
         rx_buf_q   <= '0;
         to_cnt_q   <= '0;
         rx_word_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_err_q   <= 1'b0;
      end else begin
         rx_cnt_q   <= rx_cnt_d;
         rx_buf_q   <= rx_buf_d;
         to_cnt_q   <= to_cnt_d;
         rx_word_q  <= rx_word_d;
         rx_valid_q <= rx_valid_d;
         rx_err_q   <= rx_err_d;
      end
   end

   assign o_rx_word       = rx_word_q;
   assign o_rx_word_valid = rx_valid_q;
   assign o_rx_error      = rx_err_q;

   uart_word_serializer #(
      .NB_WORD (NB_WORD),
      .NB_BYTE (NB_BYTE)
   ) u_serializer (
      .clk             (clk),
      .i_reset         (i_reset),
      .i_tx_word       (i_tx_word),
      .i_tx_word_valid (i_tx_word_valid),
      .o_tx_word_ready (o_tx_word_ready),
      .o_tx_start      (o_tx_start),
      .o_tx_data       (o_tx_data),
      .i_tx_done       (i_tx_done),
      .o_tx_word_done  (o_tx_word_done)
   );

endmodule

// File: tb/tb_uart_word_interface.sv
// Directed self-checking bench for uart_word_interface (TIMEOUT_CYCLES = 50).
module tb_uart_word_interface;

   logic        clk;
   logic        i_reset;
   logic        i_rx_done;
   logic [7:0]  i_rx_data;
   logic [31:0] o_rx_word;
   logic        o_rx_word_valid;
   logic        o_rx_error;
   logic [31:0] i_tx_word;
   logic        i_tx_word_valid;
   logic        o_tx_word_ready;
   logic        o_tx_start;
   logic [7:0]  o_tx_data;
   logic        i_tx_done;
   logic        o_tx_word_done;

   int n_cmp;
   int n_mis;
   int n_valid;
   int n_err;
   int n_start;
   int n_wdone;

   uart_word_interface #(
      .NB_WORD        (32),
      .NB_BYTE        (8),
      .TIMEOUT_CYCLES (50)
   ) dut (
      .clk             (clk),
      .i_reset         (i_reset),
      .i_rx_done       (i_rx_done),
      .i_rx_data       (i_rx_data),
      .o_rx_word       (o_rx_word),
      .o_rx_word_valid (o_rx_word_valid),
      .o_rx_error      (o_rx_error),
      .i_tx_word       (i_tx_word),
      .i_tx_word_valid (i_tx_word_valid),
      .o_tx_word_ready (o_tx_word_ready),
      .o_tx_start      (o_tx_start),
      .o_tx_data       (o_tx_data),
      .i_tx_done       (i_tx_done),
      .o_tx_word_done  (o_tx_word_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse counters sampled on the inactive edge.
   always @(negedge clk) begin
      if (o_rx_word_valid) n_valid <= n_valid + 1;
      if (o_rx_error)      n_err   <= n_err + 1;
      if (o_tx_start)      n_start <= n_start + 1;
      if (o_tx_word_done)  n_wdone <= n_wdone + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One-cycle byte pulse; returns on the negedge after the sampling edge.
   task automatic rx_byte(input logic [7:0] b);
      @(negedge clk);
      i_rx_done = 1'b1;
      i_rx_data = b;
      @(negedge clk);
      i_rx_done = 1'b0;
   endtask

   task automatic rx_word4(input logic [31:0] w, input int gap);
      for (int b = 0; b < 4; b++) begin
         logic [7:0] byte_v;
         byte_v = w[8*b +: 8];
         rx_byte(byte_v);
         if (b == 3) begin
            check("rx_valid_pulse", {31'd0, o_rx_word_valid}, 32'd1);
            check("rx_word", o_rx_word, w);
         end else begin
            check("rx_no_early_valid", {31'd0, o_rx_word_valid}, 32'd0);
            repeat (gap) @(negedge clk);
         end
      end
   endtask

   task automatic tx_word(input logic [31:0] w, input bit inject);
      int s0;
      int d0;
      logic [7:0] exp_b;
      s0 = n_start;
      d0 = n_wdone;
      @(negedge clk);
      check("tx_ready_idle", {31'd0, o_tx_word_ready}, 32'd1);
      i_tx_word       = w;
      i_tx_word_valid = 1'b1;
      @(negedge clk);
      i_tx_word_valid = 1'b0;
      i_tx_word       = 32'h0000_0000;
      for (int b = 0; b < 4; b++) begin
         exp_b = w[8*b +: 8];
         check("tx_start", {31'd0, o_tx_start}, 32'd1);
         check("tx_data", {24'd0, o_tx_data}, {24'd0, exp_b});
         check("tx_ready_busy", {31'd0, o_tx_word_ready}, 32'd0);
         @(negedge clk);
         check("tx_start_once", {31'd0, o_tx_start}, 32'd0);
         check("tx_data_hold", {24'd0, o_tx_data}, {24'd0, exp_b});
         if (inject && b == 1) begin
            i_tx_word       = 32'hAAAA_AAAA;
            i_tx_word_valid = 1'b1;
         end
         repeat (18) @(negedge clk);
         i_tx_word_valid = 1'b0;
         check("tx_ready_wait", {31'd0, o_tx_word_ready}, 32'd0);
         i_tx_done = 1'b1;
         @(negedge clk);
         i_tx_done = 1'b0;
      end
      check("tx_word_done", {31'd0, o_tx_word_done}, 32'd1);
      check("tx_ready_finish", {31'd0, o_tx_word_ready}, 32'd0);
      @(negedge clk);
      check("tx_word_done_once", {31'd0, o_tx_word_done}, 32'd0);
      check("tx_ready_after", {31'd0, o_tx_word_ready}, 32'd1);
      check("tx_start_count", n_start - s0, 32'd4);
      check("tx_done_count", n_wdone - d0, 32'd1);
   endtask

   initial begin
      int first_k;
      int e0;
      int s0;
      int d0;
      n_cmp = 0; n_mis = 0;
      n_valid = 0; n_err = 0; n_start = 0; n_wdone = 0;
      i_reset = 1'b0; i_rx_done = 1'b0; i_rx_data = 8'h00;
      i_tx_word = 32'h0; i_tx_word_valid = 1'b0; i_tx_done = 1'b0;
      #1;
      check("rst_rx_word", o_rx_word, 32'h0);
      check("rst_tx_ready", {31'd0, o_tx_word_ready}, 32'd1);
      check("rst_tx_start", {31'd0, o_tx_start}, 32'd0);
      check("rst_tx_data", {24'd0, o_tx_data}, 32'h0);
      check("rst_rx_valid", {31'd0, o_rx_word_valid}, 32'd0);
      repeat (2) @(negedge clk);
      i_reset = 1'b1;

      // Basic RX word, bytes 10 clk apart
      rx_word4(32'h1234_5678, 9);
      repeat (3) @(negedge clk);
      check("rx_valid_count", n_valid, 32'd1);
      check("rx_no_error", n_err, 32'd0);

      // Basic TX word
      tx_word(32'hDEAD_BEEF, 1'b0);

      // Timeout after two bytes
      rx_byte(8'h11);
      rx_byte(8'h22);
      e0 = n_err;
      first_k = 0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (o_rx_error && first_k == 0) first_k = k;
      end
      check("timeout_latency", first_k, 32'd49);
      check("timeout_pulses", n_err - e0, 32'd1);
      check("timeout_word_kept", o_rx_word, 32'h1234_5678);
      rx_word4(32'h0102_0304, 2);

      // Byte lands exactly on the expiry cycle
      e0 = n_err;
      rx_byte(8'hA1);
      rx_byte(8'hB2);
      repeat (47) @(negedge clk);
      rx_byte(8'hC3);
      rx_byte(8'hD4);
      check("expiry_byte_wins_valid", {31'd0, o_rx_word_valid}, 32'd1);
      check("expiry_byte_wins_word", o_rx_word, 32'hD4C3_B2A1);
      repeat (2) @(negedge clk);
      check("expiry_no_error", n_err - e0, 32'd0);

      // Valid during WAIT is ignored
      tx_word(32'h1357_9BDF, 1'b1);

      // Stray done in IDLE
      s0 = n_start;
      @(negedge clk);
      i_tx_done = 1'b1;
      @(negedge clk);
      i_tx_done = 1'b0;
      repeat (3) @(negedge clk);
      check("stray_done_no_start", n_start - s0, 32'd0);
      check("stray_done_ready", {31'd0, o_tx_word_ready}, 32'd1);

      // Asynchronous reset mid RX word and mid TX byte 1
      rx_byte(8'h55);
      rx_byte(8'h66);
      @(negedge clk);
      i_tx_word = 32'h1122_3344;
      i_tx_word_valid = 1'b1;
      @(negedge clk);
      i_tx_word_valid = 1'b0;
      repeat (4) @(negedge clk);
      i_tx_done = 1'b1;
      @(negedge clk);
      i_tx_done = 1'b0;
      @(negedge clk);
      check("pre_rst_byte1", {24'd0, o_tx_data}, 32'h33);
      e0 = n_err;
      d0 = n_wdone;
      #2;
      i_reset = 1'b0;
      #1;
      check("arst_rx_word", o_rx_word, 32'h0);
      check("arst_tx_ready", {31'd0, o_tx_word_ready}, 32'd1);
      check("arst_tx_start", {31'd0, o_tx_start}, 32'd0);
      check("arst_tx_data", {24'd0, o_tx_data}, 32'h0);
      check("arst_word_done", {31'd0, o_tx_word_done}, 32'd0);
      @(negedge clk);
      i_reset = 1'b1;
      rx_word4(32'hCAFE_F00D, 1);
      repeat (60) @(negedge clk);
      check("post_rst_no_error", n_err - e0, 32'd0);
      check("post_rst_no_done", n_wdone - d0, 32'd0);
      check("post_rst_word_held", o_rx_word, 32'hCAFE_F00D);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/uart_word_interface.md
Name: uart_word_interface

Overview:
- Sits between the UART core's byte-level rx/tx ports and the processor/debug logic.
- RX path: assembles consecutive received bytes into NB_WORD-bit words, least significant byte first. A partially filled word is discarded if the inter-byte gap exceeds a timeout.
- TX path: accepts a word through a valid/ready handshake and serializes it to the UART transmitter one byte at a time, LSB first, pacing each byte on the transmitter's done pulse.

Parameters:
- NB_WORD, 32, word width in bits; must be a multiple of NB_BYTE.
- NB_BYTE, 8, UART byte width.
- TIMEOUT_CYCLES, 4_500_000, max clk cycles between bytes of one RX word (100 ms at 45 MHz); 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- i_reset  in  1  reset, asynchronous, active-low.
- i_rx_done  in  1  one-cycle pulse from the UART receiver: i_rx_data is valid.
- i_rx_data  in  NB_BYTE  received byte.
- o_rx_word  out  NB_WORD  last fully assembled word.
- o_rx_word_valid  out  1  one-cycle pulse: o_rx_word updated.
- o_rx_error  out  1  one-cycle pulse: partial word discarded on timeout.
- i_tx_word  in  NB_WORD  word to transmit.
- i_tx_word_valid  in  1  request to transmit i_tx_word.
- o_tx_word_ready  out  1  TX path idle, can accept a word.
- o_tx_start  out  1  one-cycle pulse to the UART transmitter.
- o_tx_data  out  NB_BYTE  byte presented to the UART transmitter.
- i_tx_done  in  1  one-cycle pulse from the UART transmitter: byte finished.
- o_tx_word_done  out  1  one-cycle pulse: last byte of the word finished.

Behaviour:
- Reset values (asynchronous, active-low):
  - All outputs 0, except o_tx_word_ready = 1.
  - Byte counters, timeout counter, shift register and latched TX word cleared.
  - TX FSM in IDLE.
  - Reset mid-word drops any partial RX word and any in-flight TX word; no done or error pulse is emitted.
- Derived constant: NB_BYTES = NB_WORD/NB_BYTE. Byte index width = clog2(NB_BYTES), minimum 1.
- RX path:
  - On i_rx_done, i_rx_data is written into byte slot rx_cnt (slot 0 = bits [NB_BYTE-1:0]) and rx_cnt increments.
  - When the byte with rx_cnt == NB_BYTES-1 is received, the whole word is copied to o_rx_word on the next edge. o_rx_word_valid pulses in that same cycle (latency: one clk after the last i_rx_done). rx_cnt then wraps to 0.
  - o_rx_word holds its value until the next complete word.
- RX timeout:
  - The counter runs only while rx_cnt != 0 and is cleared on every i_rx_done.
  - When it reaches TIMEOUT_CYCLES-1 without a byte: rx_cnt goes to 0, o_rx_error pulses for 1 cycle, and o_rx_word is unchanged.
  - If i_rx_done arrives in the same cycle as expiry, the byte wins: it is accepted, the counter clears, and there is no error.
- TX FSM states: IDLE, SEND, WAIT, FINISH.
  - IDLE: o_tx_word_ready = 1. On i_tx_word_valid && o_tx_word_ready, latch i_tx_word, set tx_idx = 0, go to SEND.
  - SEND: o_tx_start = 1 for exactly this cycle; o_tx_data = byte tx_idx; go to WAIT. The first start therefore occurs 1 cycle after acceptance.
  - WAIT: o_tx_data stays stable. On i_tx_done: if tx_idx == NB_BYTES-1 go to FINISH, else increment tx_idx and go to SEND.
  - FINISH: o_tx_word_done = 1 for one cycle, then IDLE. o_tx_word_ready returns high the cycle after FINISH.
- TX boundary rules:
  - o_tx_word_ready is low in SEND, WAIT and FINISH; i_tx_word_valid is ignored there.
  - i_tx_done in IDLE, SEND or FINISH is ignored.
  - i_tx_word may change after acceptance without effect.
- RX and TX paths are fully independent; simultaneous activity is legal.

Decomposition:
- Shared package holds NB_BYTE, the TX state encoding (IDLE=2'b00, SEND=2'b01, WAIT=2'b10, FINISH=2'b11), and a clog2 helper function.
- One natural sub-module: uart_word_serializer (the TX FSM plus latched word). RX assembly and timeout stay in the top level.

Test Plan:
- RX bytes 0x78, 0x56, 0x34, 0x12, 10 clk apart -> one o_rx_word_valid pulse 1 clk after the 4th i_rx_done with o_rx_word = 0x12345678; o_rx_error never asserted.
- TX accept 0xDEADBEEF; bench returns i_tx_done 20 clk after each start -> o_tx_start pulses carry 0xEF, 0xBE, 0xAD, 0xDE in order; o_tx_word_done pulses once; o_tx_word_ready is low throughout and high 1 clk after done.
- TIMEOUT_CYCLES = 50: send 2 bytes, then wait 60 clk -> o_rx_error pulses 1 cycle, 49 clk after the 2nd byte. Then 0x04, 0x03, 0x02, 0x01 -> o_rx_word = 0x01020304.
- TIMEOUT_CYCLES = 50: a byte arrives exactly on the expiry cycle -> no error; the word completes normally.
- Assert i_tx_word_valid with 0xAAAAAAAA during WAIT of a word in flight -> ignored; only the original 4 bytes are sent. Stray i_tx_done in IDLE -> no o_tx_start.
- Assert i_reset low after 2 RX bytes and mid-TX byte 1 -> all outputs at reset values immediately (asynchronously); after release, a fresh 4-byte RX word assembles correctly and no stale done pulse appears.
